// File: rtl/multiply_divide_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation select,
// FSM state codes and the default operand width.
package multiply_divide_unit_pkg;

    localparam int MDU_DWL = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_SIGN = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    function automatic logic is_div(input logic [1:0] sel);
        return sel[1];
    endfunction

    function automatic logic is_signed_op(input logic [1:0] sel);
        return ~sel[0];
    endfunction

endpackage

// File: rtl/multiply_divide_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle over a single 2*DWL shift register shared by both operations.
module multiply_divide_unit
    import multiply_divide_unit_pkg::*;
#(
    parameter int DWL = MDU_DWL,
    parameter int CW  = 6
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           Start,
    input  logic [1:0]     MDSel,
    input  logic [DWL-1:0] MDIn1,
    input  logic [DWL-1:0] MDIn2,
    input  logic           WriteHI,
    input  logic           WriteLO,
    output logic           Busy,
    output logic           Done,
    output logic [DWL-1:0] HI,
    output logic [DWL-1:0] LO,
    output logic           DivByZero
);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [2*DWL-1:0] r_acc;
    logic [DWL-1:0]   r_op2;
    logic [1:0]       r_sel;
    logic             r_sign1;
    logic             r_sign2;
    logic [DWL-1:0]   r_hi;
    logic [DWL-1:0]   r_lo;
    logic             r_dbz;

    logic             w_accept;
    logic             w_dbz_start;
    logic             w_signed_in;
    logic [DWL-1:0]   w_in1_mag;
    logic [DWL-1:0]   w_in2_mag;
    logic [DWL:0]     w_add;
    logic [DWL:0]     w_trial;
    logic [2*DWL-1:0] w_step;
    logic [2*DWL-1:0] w_prod;
    logic [DWL-1:0]   w_quo;
    logic [DWL-1:0]   w_rem;
    logic [DWL-1:0]   w_res_hi;
    logic [DWL-1:0]   w_res_lo;

    assign w_accept    = (r_state == ST_IDLE) && Start;
    assign w_dbz_start = w_accept && is_div(MDSel) && (MDIn2 == {DWL{1'b0}});
    assign w_signed_in = is_signed_op(MDSel);
    assign w_in1_mag   = (w_signed_in && MDIn1[DWL-1]) ? (~MDIn1 + DWL'(1)) : MDIn1;
    assign w_in2_mag   = (w_signed_in && MDIn2[DWL-1]) ? (~MDIn2 + DWL'(1)) : MDIn2;

    // One iteration step: multiply adds into the upper half and shifts right,
    // divide shifts left and keeps the trial difference when it does not borrow.
    always_comb begin
        w_add   = {1'b0, r_acc[2*DWL-1:DWL]} + (r_acc[0] ? {1'b0, r_op2} : {(DWL+1){1'b0}});
        w_trial = r_acc[2*DWL-1:DWL-1] - {1'b0, r_op2};
        w_step  = r_acc;
        if (is_div(r_sel)) begin
            if (!w_trial[DWL]) begin
                w_step = {w_trial[DWL-1:0], r_acc[DWL-2:0], 1'b1};
            end else begin
                w_step = {r_acc[2*DWL-2:0], 1'b0};
            end
        end else begin
            w_step = {w_add, r_acc[DWL-1:1]};
        end
    end

    // Sign fix-up of the unsigned magnitude result; remainder follows the dividend.
    always_comb begin
        w_prod = r_acc;
        w_quo  = r_acc[DWL-1:0];
        w_rem  = r_acc[2*DWL-1:DWL];
        if (is_signed_op(r_sel) && (r_sign1 ^ r_sign2)) begin
            w_prod = ~r_acc + (2*DWL)'(1);
            w_quo  = ~r_acc[DWL-1:0] + DWL'(1);
        end else begin
            w_prod = r_acc;
            w_quo  = r_acc[DWL-1:0];
        end
        if (is_signed_op(r_sel) && r_sign1) begin
            w_rem = ~r_acc[2*DWL-1:DWL] + DWL'(1);
        end else begin
            w_rem = r_acc[2*DWL-1:DWL];
        end
        if (is_div(r_sel)) begin
            w_res_hi = w_rem;
            w_res_lo = w_quo;
        end else begin
            w_res_hi = w_prod[2*DWL-1:DWL];
            w_res_lo = w_prod[DWL-1:0];
        end
    end

    // Sequencer and iteration datapath.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_acc   <= {(2*DWL){1'b0}};
            r_op2   <= {DWL{1'b0}};
            r_sel   <= 2'b00;
            r_sign1 <= 1'b0;
            r_sign2 <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_sel   <= MDSel;
                        r_sign1 <= w_signed_in & MDIn1[DWL-1];
                        r_sign2 <= w_signed_in & MDIn2[DWL-1];
                        r_cnt   <= {CW{1'b0}};
                        if (is_div(MDSel)) begin
                            r_acc <= {{DWL{1'b0}}, w_in1_mag};
                            r_op2 <= w_in2_mag;
                        end else begin
                            r_acc <= {{DWL{1'b0}}, w_in2_mag};
                            r_op2 <= w_in1_mag;
                        end
                        r_state <= w_dbz_start ? ST_DONE : ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(DWL - 1)) begin
                        r_state <= ST_SIGN;
                    end
                end
                ST_SIGN: r_state <= ST_DONE;
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Architectural HI/LO and the sticky divide-by-zero flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hi  <= {DWL{1'b0}};
            r_lo  <= {DWL{1'b0}};
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_dbz <= w_dbz_start;
            if (w_dbz_start) begin
                r_hi <= MDIn1;
                r_lo <= {DWL{1'b1}};
            end
        end else if (r_state == ST_IDLE) begin
            if (WriteHI) begin
                r_hi <= MDIn1;
            end
            if (WriteLO) begin
                r_lo <= MDIn1;
            end
        end else if (r_state == ST_SIGN) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end
    end

    assign Busy      = (r_state != ST_IDLE);
    assign Done      = (r_state == ST_DONE);
    assign HI        = r_hi;
    assign LO        = r_lo;
    assign DivByZero = r_dbz;

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Scoreboard bench for multiply_divide_unit: directed operations push expected
// HI/LO/DivByZero, a monitor pops and compares on every Done pulse.
module tb_multiply_divide_unit;
    import multiply_divide_unit_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic        CLK;
    logic        RST;
    logic        Start;
    logic [1:0]  MDSel;
    logic [31:0] MDIn1;
    logic [31:0] MDIn2;
    logic        WriteHI;
    logic        WriteLO;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        DivByZero;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cyc;
    int   busy_cnt;

    multiply_divide_unit #(.DWL(32), .CW(6)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .MDSel(MDSel),
        .MDIn1(MDIn1), .MDIn2(MDIn2), .WriteHI(WriteHI), .WriteLO(WriteLO),
        .Busy(Busy), .Done(Done), .HI(HI), .LO(LO), .DivByZero(DivByZero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every Done pulse is matched against the oldest expected result.
    always @(negedge CLK) begin
        if (Done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_hi", 64'(HI), 64'(e.hi));
                check("sb_lo", 64'(LO), 64'(e.lo));
                check("sb_dbz", 64'(DivByZero), 64'(e.dbz));
            end
        end
    end

    // Called at a negedge; Start is sampled at the following posedge.
    task automatic issue(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic wr_hi, input logic wr_lo, input bit push,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
        exp_t e;
        Start = 1'b1; MDSel = sel; MDIn1 = a; MDIn2 = b;
        WriteHI = wr_hi; WriteLO = wr_lo;
        if (push) begin
            e.hi = ehi; e.lo = elo; e.dbz = edbz;
            sb_q.push_back(e);
        end
        @(negedge CLK);
        Start = 1'b0; WriteHI = 1'b0; WriteLO = 1'b0;
    endtask

    // Counts cycles from the current negedge until Busy falls, with a bound.
    task automatic run_wait(input int first_cyc, output int d_cyc, output int b_cnt);
        d_cyc = 0;
        b_cnt = 0;
        for (int i = first_cyc; i < first_cyc + 100; i++) begin
            if (Busy) b_cnt++;
            if (Done && d_cyc == 0) d_cyc = i;
            if (!Busy) break;
            @(negedge CLK);
        end
        if (Busy) check("busy_timeout", 64'd1, 64'd0);
    endtask

    task automatic mtx(input logic wr_hi, input logic wr_lo, input logic [31:0] v);
        WriteHI = wr_hi; WriteLO = wr_lo; MDIn1 = v;
        @(negedge CLK);
        WriteHI = 1'b0; WriteLO = 1'b0;
    endtask

    initial begin
        RST = 1'b1; Start = 1'b0; MDSel = 2'b00; MDIn1 = 32'd0; MDIn2 = 32'd0;
        WriteHI = 1'b0; WriteLO = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_hi", 64'(HI), 64'd0);
        check("rst_lo", 64'(LO), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_dbz", 64'(DivByZero), 64'd0);

        // Start driven in the same cycle reset is released.
        RST = 1'b0;
        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_wait(1, done_cyc, busy_cnt);
        check("multu_latency", 64'(done_cyc), 64'd34);
        check("multu_busy_cycles", 64'(busy_cnt), 64'd34);

        issue(MD_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_wait(1, done_cyc, busy_cnt);
        issue(MD_MULT, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 32'h40000000, 32'h00000000, 1'b0);
        run_wait(1, done_cyc, busy_cnt);
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_wait(1, done_cyc, busy_cnt);
        issue(MD_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1, 32'd2, 32'd14, 1'b0);
        run_wait(1, done_cyc, busy_cnt);
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'h00000000, 32'h80000000, 1'b0);
        run_wait(1, done_cyc, busy_cnt);
        issue(MD_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000003, 1'b0);
        run_wait(1, done_cyc, busy_cnt);
        issue(MD_DIV, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        run_wait(1, done_cyc, busy_cnt);

        // Divide by zero completes immediately and leaves a sticky flag.
        issue(MD_DIVU, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1, 32'd5, 32'hFFFFFFFF, 1'b1);
        run_wait(1, done_cyc, busy_cnt);
        check("dbz_latency", 64'(done_cyc), 64'd1);
        @(negedge CLK);
        check("dbz_sticky", 64'(DivByZero), 64'd1);
        issue(MD_MULTU, 32'd3, 32'd5, 1'b0, 1'b0, 1'b1, 32'd0, 32'd15, 1'b0);
        check("dbz_cleared", 64'(DivByZero), 64'd0);
        run_wait(1, done_cyc, busy_cnt);

        // Start and WriteHI while busy are ignored.
        issue(MD_MULTU, 32'd6, 32'd7, 1'b0, 1'b0, 1'b1, 32'd0, 32'd42, 1'b0);
        repeat (9) @(negedge CLK);
        Start = 1'b1; MDSel = MD_DIVU; MDIn1 = 32'hDEAD; MDIn2 = 32'd0; WriteHI = 1'b1;
        @(negedge CLK);
        Start = 1'b0; WriteHI = 1'b0;
        run_wait(11, done_cyc, busy_cnt);
        check("busy_ignore_latency", 64'(done_cyc), 64'd34);
        repeat (3) @(negedge CLK);
        check("busy_ignore_idle", 64'(Busy), 64'd0);

        mtx(1'b0, 1'b1, 32'h1234);
        check("mtlo_lo", 64'(LO), 64'h1234);
        check("mtlo_hi_kept", 64'(HI), 64'd0);
        mtx(1'b1, 1'b0, 32'h55);
        check("mthi_hi", 64'(HI), 64'h55);

        // Start wins over a coincident WriteHI: HI must hold during the op.
        issue(MD_MULTU, 32'd2, 32'd3, 1'b1, 1'b0, 1'b1, 32'd0, 32'd6, 1'b0);
        check("start_wins_hi", 64'(HI), 64'h55);
        run_wait(1, done_cyc, busy_cnt);

        // Reset in the middle of a divide.
        mtx(1'b1, 1'b0, 32'h77);
        issue(MD_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (19) @(negedge CLK);
        RST = 1'b1;
        #1;
        check("midrst_hi", 64'(HI), 64'd0);
        check("midrst_lo", 64'(LO), 64'd0);
        check("midrst_busy", 64'(Busy), 64'd0);
        check("midrst_done", 64'(Done), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        issue(MD_MULTU, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1, 32'd0, 32'd12, 1'b0);
        run_wait(1, done_cyc, busy_cnt);
        check("post_rst_latency", 64'(done_cyc), 64'd34);

        repeat (3) @(negedge CLK);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
